// File: rtl/ddr_pkg.sv
// Shared MCB command codes, frame geometry defaults and frame-reader FSM states.
package ddr_pkg;

  localparam logic [2:0] CmdWrite = 3'b000;
  localparam logic [2:0] CmdRead  = 3'b001;

  localparam int unsigned DefBurstWords = 64;
  localparam int unsigned DefFrameWords = 70656;

  localparam logic [29:0] DefFrame0Base = 30'd0;
  localparam logic [29:0] DefFrame1Base = 30'(DefFrameWords * 4);

  typedef enum logic [2:0] {
    StWaitCal = 3'd0,
    StIdle    = 3'd1,
    StCmd     = 3'd2,
    StDrain   = 3'd3,
    StLast    = 3'd4,
    StFlush   = 3'd5
  } rd_state_e;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output register: load wins, otherwise an accepted word empties it.
module stream_out_reg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_data,
  input  logic             ready,
  output logic [Width-1:0] data,
  output logic             valid
);

  logic [Width-1:0] data_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= load_data;
      valid_q <= 1'b1;
    end else if (ready) begin
      valid_q <= 1'b0;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/ddr_port1_frame_reader.sv
// Reads a finished frame out of DDR over MCB port 1 in fixed bursts and streams it downstream.
module ddr_port1_frame_reader
  import ddr_pkg::*;
#(
  parameter int unsigned BURST_WORDS = DefBurstWords,
  parameter int unsigned FRAME_WORDS = DefFrameWords,
  parameter logic [29:0] FRAME0_BASE = DefFrame0Base,
  parameter logic [29:0] FRAME1_BASE = DefFrame1Base
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic        memory_frame,
  input  logic        frame_req,
  input  logic        p1_cmd_full,
  input  logic        p1_rd_empty,
  input  logic [6:0]  p1_rd_count,
  input  logic [31:0] p1_rd_data,
  input  logic        p1_rd_overflow,
  output logic        p1_cmd_en,
  output logic [2:0]  p1_cmd_instr,
  output logic [5:0]  p1_cmd_bl,
  output logic [29:0] p1_cmd_byte_addr,
  output logic        p1_rd_en,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        rd_error
);

  localparam int unsigned WlW        = $clog2(FRAME_WORDS + 1);
  localparam int unsigned BlW        = $clog2(BURST_WORDS + 1);
  localparam logic [29:0] BurstBytes = 30'(BURST_WORDS * 4);
  localparam logic [5:0]  CmdBl      = 6'(BURST_WORDS - 1);

  rd_state_e      state_q, state_d;
  logic [29:0]    ptr_q, ptr_d;
  logic [WlW-1:0] words_left_q, words_left_d;
  logic [BlW-1:0] burst_left_q, burst_left_d;
  logic           busy_q, busy_d;
  logic           frame_done_q;
  logic           rd_error_q;
  logic           cal_meta_q, cal_sync_q;

  logic cmd_fire, drain_pop, flush_pop, accept_last;

  // Occupancy is not needed: emptiness alone gates every pop.
  logic unused_rd_count;
  assign unused_rd_count = ^p1_rd_count;

  assign cmd_fire    = (state_q == StCmd) && !p1_cmd_full;
  assign drain_pop   = (state_q == StDrain) && !p1_rd_empty && (!pix_valid || pix_ready) &&
                       (burst_left_q != '0);
  assign flush_pop   = (state_q == StFlush) && !p1_rd_empty;
  assign accept_last = (state_q == StLast) && pix_valid && pix_ready;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    words_left_d = words_left_q;
    burst_left_d = burst_left_q;
    busy_d       = busy_q;
    unique case (state_q)
      StWaitCal: begin
        // Leftovers from a burst abandoned by reset are drained before accepting work.
        if (cal_sync_q) state_d = p1_rd_empty ? StIdle : StFlush;
      end
      StIdle: begin
        if (frame_req) begin
          ptr_d        = memory_frame ? FRAME0_BASE : FRAME1_BASE;
          words_left_d = WlW'(FRAME_WORDS);
          busy_d       = 1'b1;
          state_d      = StCmd;
        end
      end
      StCmd: begin
        if (cmd_fire) begin
          ptr_d        = ptr_q + BurstBytes;
          burst_left_d = BlW'(BURST_WORDS);
          state_d      = StDrain;
        end
      end
      StDrain: begin
        if (drain_pop) begin
          burst_left_d = burst_left_q - BlW'(1);
          words_left_d = words_left_q - WlW'(1);
          if (burst_left_q == BlW'(1)) begin
            state_d = (words_left_q == WlW'(1)) ? StLast : StCmd;
          end
        end
      end
      StLast: begin
        if (accept_last) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StFlush: begin
        if (p1_rd_empty) state_d = StIdle;
      end
      default: state_d = StWaitCal;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StWaitCal;
      ptr_q        <= '0;
      words_left_q <= '0;
      burst_left_q <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rd_error_q   <= 1'b0;
      cal_meta_q   <= 1'b0;
      cal_sync_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      words_left_q <= words_left_d;
      burst_left_q <= burst_left_d;
      busy_q       <= busy_d;
      frame_done_q <= accept_last;
      rd_error_q   <= rd_error_q | p1_rd_overflow;
      cal_meta_q   <= mem_calib_done;
      cal_sync_q   <= cal_meta_q;
    end
  end

  stream_out_reg #(
    .Width(32)
  ) u_stream_out_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (drain_pop),
    .load_data(p1_rd_data),
    .ready    (pix_ready),
    .data     (pix_data),
    .valid    (pix_valid)
  );

  assign p1_cmd_en        = cmd_fire;
  assign p1_cmd_instr     = CmdRead;
  assign p1_cmd_bl        = cmd_fire ? CmdBl : '0;
  assign p1_cmd_byte_addr = cmd_fire ? ptr_q : '0;
  assign p1_rd_en         = drain_pop | flush_pop;
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;
  assign rd_error         = rd_error_q;

endmodule

// File: doc/ddr_port1_frame_reader.md
Name: ddr_port1_frame_reader

Overview:
- Read-side companion to the port-0 frame writer.
- Pulls a completed Mandelbrot frame out of DDR through MCB port 1 in 64-word read bursts.
- Presents the words as a valid/ready stream to the downstream pixel/VGA FIFO.
- Sits between the MCB user port 1 and the display path. Reads whichever frame buffer the writer is not currently filling, as selected by memory_frame.

Parameters:
- BURST_WORDS, 64, words per read command; p1_cmd_bl = BURST_WORDS-1; must be 1..64.
- FRAME_WORDS, 70656, 32-bit words per frame; must be a multiple of BURST_WORDS.
- FRAME0_BASE, 30'd0, byte address of frame buffer 0.
- FRAME1_BASE, 30'd282624, byte address of frame buffer 1; equals FRAME_WORDS*4.

Ports:
- clk  in  1  system/MCB user clock
- reset  in  1  synchronous, active-high
- mem_calib_done  in  1  MCB calibration complete; asynchronous to the FSM, synchronised internally
- memory_frame  in  1  frame buffer the writer is filling; reader uses the other one
- frame_req  in  1  pulse: start reading one frame
- p1_cmd_full  in  1  MCB command FIFO full
- p1_rd_empty  in  1  MCB read FIFO empty
- p1_rd_count  in  7  MCB read FIFO occupancy
- p1_rd_data  in  32  MCB read data, first-word-fall-through
- p1_rd_overflow  in  1  MCB read FIFO overflow
- p1_cmd_en  out  1  command strobe
- p1_cmd_instr  out  3  command; always 3'b001 (read)
- p1_cmd_bl  out  6  burst length minus one
- p1_cmd_byte_addr  out  30  burst byte address
- p1_rd_en  out  1  read FIFO pop
- pix_data  out  32  stream data
- pix_valid  out  1  stream valid
- pix_ready  in  1  downstream accepts
- busy  out  1  frame read in progress
- frame_done  out  1  one-cycle pulse after the last word of a frame is accepted
- rd_error  out  1  sticky overflow flag; cleared only by reset

Behaviour:
- Reset: all outputs are 0, p1_cmd_instr is 3'b001, and the FSM goes to WAIT_CAL.
  - Also clears the 2-flop calibration synchroniser, the word counter and the address pointer.
- A reset mid-burst abandons the burst.
  - Data still in the MCB FIFO is drained silently in FLUSH (rd_en held high while !p1_rd_empty) before IDLE.
  - Nothing from the flush reaches pix_*.
- WAIT_CAL -> IDLE when the synchronised calibration bit is 1.
- IDLE: on frame_req, latch base = memory_frame ? FRAME0_BASE : FRAME1_BASE (the opposite buffer). Set ptr = base, words_left = FRAME_WORDS, busy = 1, then go to CMD.
  - frame_req while busy is ignored.
- CMD: when !p1_cmd_full, assert p1_cmd_en for exactly 1 cycle with bl = BURST_WORDS-1 and addr = ptr. Then ptr += BURST_WORDS*4 and go to DRAIN with burst_left = BURST_WORDS.
- DRAIN: p1_rd_en = !p1_rd_empty && (!pix_valid || pix_ready) && burst_left != 0. This is combinational, and is the only pop source outside FLUSH.
  - On a pop: pix_data <= p1_rd_data, pix_valid <= 1, burst_left and words_left decrement.
  - If pix_ready && the output register is not reloaded, pix_valid <= 0.
  - Throughput is 1 word/cycle when the upstream FIFO is fed and pix_ready is high. Latency from pop to pix_valid is 1 cycle.
  - When burst_left reaches 0: go to CMD if words_left != 0, else go to LAST.
- LAST: wait for the final word to be accepted (pix_valid && pix_ready). Pulse frame_done, clear busy, go to IDLE.
- Never more than one read command is outstanding.
- The pointer is 30-bit and wraps modulo 2^30; no range check.
- p1_rd_overflow sets rd_error in any state. Operation continues.

Decomposition:
- Shared package ddr_pkg:
  - MCB instruction codes: CMD_WRITE = 3'b000, CMD_READ = 3'b001.
  - BURST_WORDS default.
  - Frame base addresses and FRAME_WORDS.
  - FSM state encodings: WAIT_CAL, IDLE, CMD, DRAIN, LAST, FLUSH.
- One natural sub-module: stream_out_reg, the single-entry valid/ready output register with its load/clear logic.
- The FSM and counters stay in the top level.

Test Plan:
- Calibration gating: hold mem_calib_done=0 and pulse frame_req → no p1_cmd_en. Raise mem_calib_done → FSM reaches IDLE 2-3 cycles later.
- Full frame, pix_ready=1, FRAME_WORDS=128 override, memory_frame=0:
  - Exactly two commands: instr 001, bl 63, addrs 282624 then 282880.
  - 128 words emitted in order.
  - frame_done pulses once. busy=0 afterwards.
- Buffer select: memory_frame=1 → first command addr = 0.
- Backpressure: pix_ready toggled pseudo-randomly → no word lost or duplicated (sequence model check), and p1_rd_en=0 whenever pix_valid && !pix_ready.
- Command FIFO full: p1_cmd_full=1 for 10 cycles in CMD → p1_cmd_en stays 0. It asserts for 1 cycle on the first cycle p1_cmd_full=0.
- Reset after 20 words of a burst:
  - The 44 remaining MCB words are popped in FLUSH with pix_valid=0.
  - A following frame_req restarts at the base address.
  - p1_rd_overflow pulse → rd_error=1 until reset.
